// File: rtl/nibble_serial_adder.sv
// Multi-word adder sequencer: feeds one nibble pair per cycle through a single
// 4-bit ripple-carry adder and presents the full sum, carry-out and overflow.

module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             carry_reg;
  logic             a_top_reg;
  logic             b_top_reg;
  logic             cout_reg;
  logic             overflow_reg;
  logic             overflow_next;
  logic             last_step;

  logic [3:0] add_s;
  logic       add_cout;

  ripple_carry_adder u_rca (
    .a    (a_sh_reg[3:0]),
    .b    (b_sh_reg[3:0]),
    .cin  (carry_reg),
    .s    (add_s),
    .cout (add_cout)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom.
  always_comb begin
    acc_next      = {add_s, acc_reg[WIDTH-1:4]};
    last_step     = (idx_reg == LAST_IDX);
    overflow_next = (a_top_reg == b_top_reg) && (acc_next[WIDTH-1] != a_top_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_ADD;
      S_ADD:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_top_reg    <= 1'b0;
      b_top_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= cin;
            a_top_reg <= a[WIDTH-1];
            b_top_reg <= b[WIDTH-1];
            idx_reg   <= '0;
            acc_reg   <= '0;
          end
        end
        S_ADD: begin
          acc_reg   <= acc_next;
          a_sh_reg  <= {4'b0000, a_sh_reg[WIDTH-1:4]};
          b_sh_reg  <= {4'b0000, b_sh_reg[WIDTH-1:4]};
          carry_reg <= add_cout;
          idx_reg   <= idx_reg + IDXW'(1);
          if (last_step) begin
            sum_reg      <= acc_next;
            cout_reg     <= add_cout;
            overflow_reg <= overflow_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign done     = (state_reg == S_DONE);
  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): reset, arithmetic,
// overflow, handshake and mid-operation reset scenarios.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int lat;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, ".ready"},    32'(ready),    32'd1);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".done"},     32'(done),     32'd0);
    chk({tag, ".sum"},      32'(sum),      32'h0);
    chk({tag, ".cout"},     32'(cout),     32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  // Issue one start in IDLE, then watch for done with a bounded wait.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~cv;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(posedge clk);
      else wait (1);
      if (i > 1) #1;
      if (i == 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, ".latency"},  32'(lat),      32'd4);
    chk({tag, ".sum"},      32'(sum),      32'(es));
    chk({tag, ".cout"},     32'(cout),     32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk({tag, ".done_low"}, 32'(done),     32'd0);
    chk({tag, ".ready"},    32'(ready),    32'd1);
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, av, bv, cv, sum, cout, overflow, lat);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    #2;
    check_idle_reset("rst_hold");
    #1 rst_n = 1'b1;
    #1;
    check_idle_reset("rst_release");
    start = 1'b0;
    $display("reset ready=%0d busy=%0d done=%0d sum=%h", ready, busy, done, sum);

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Handshake: starts during ADD and DONE must be ignored.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 16'hAAAA; b = 16'h5555;
    chk("hs.busy_add", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("hs.done", 32'(done), 32'd1);
    chk("hs.sum",  32'(sum),  32'h0007);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    chk("hs.ready_after_done", 32'(ready), 32'd1);
    chk("hs.done_low",         32'(done),  32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("hs.not_accepted", 32'(ready), 32'd1);
    $display("handshake sum=%h ready=%0d", sum, ready);
    run_op("hs_next", 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0);

    // Mid-operation reset after E2.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle_reset("midrst");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      chk("midrst.no_done", 32'(done),  32'd0);
      chk("midrst.ready",   32'(ready), 32'd1);
    end
    $display("midrst ready=%0d done=%0d sum=%h", ready, done, sum);
    run_op("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-word adder sequencer that sits directly upstream of the 4-bit `ripple_carry_adder`. It accepts two WIDTH-bit operands and a carry-in through a start handshake. Each cycle it feeds one nibble pair and the registered carry into a single `ripple_carry_adder` instance. It collects the `s` and `cout` results nibble by nibble, then presents the full sum, the carry-out and a signed-overflow flag with a one-cycle `done` pulse.

## Interface

Reset and clock decision: one clock `clk`; reset `rst_n` is asynchronous and active-low.

Parameters:
- WIDTH, default 16: operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, derived as WIDTH/4: number of nibble steps. This is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to add; sampled only while `ready`=1
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in to nibble 0; captured on the accepting edge
- ready  output  1  high in IDLE only
- busy  output  1  high in ADD and DONE
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  registered result; holds until the next completion
- cout  output  1  carry out of the top nibble; registered, holds
- overflow  output  1  two's-complement overflow; registered, holds

## Operation

- The FSM has three states: IDLE, ADD and DONE. Encoding is free; it resets to IDLE.
- IDLE: `ready`=1.
  - If `start`=1, capture a, b and cin into `a_sh`, `b_sh` and `carry_q`.
  - Clear `idx` to 0 and the internal `acc` register.
  - Move to ADD.
- ADD: each cycle the adder instance receives `a_sh[3:0]`, `b_sh[3:0]` and `carry_q`. On the edge:
  - `acc` shifts right by 4, and adder `s` enters `acc[WIDTH-1:WIDTH-4]`.
  - `a_sh` and `b_sh` shift right by 4, zero-filled.
  - `carry_q` takes adder `cout`.
  - `idx` increments.
  - When `idx`==NIB-1 on that edge, move to DONE.
- Result load: on the edge that leaves ADD, the outputs load as follows.
  - `sum` takes the final `acc` value, including the last nibble.
  - `cout` takes adder `cout`.
  - `overflow` = (a_top==b_top) && (sum_top!=a_top). The *_top bits are bit WIDTH-1 of the captured operands and of the final sum; `a_sh` and `b_sh` keep bit WIDTH-1 copies for this.
- DONE: `done`=1 for exactly one cycle, then move to IDLE unconditionally.
- Start while busy: `start` in ADD or DONE is ignored, with no queueing. A new operation can begin only in the cycle after DONE.
- Arithmetic: the result is the unsigned sum a+b+cin, modulo 2^WIDTH, with the carry reported on `cout`. {cout,sum} must equal a+b+cin exactly.
- Register sizing: `idx` is ceil(log2(NIB)) bits wide and must not wrap before the DONE transition.
- Operand stability: the operand inputs are don't-care after the accepting edge. Changes during ADD must not affect the result.
- Reset: `rst_n` low at any time, including mid-ADD, forces the following immediately, with no clock needed.
  - State goes to IDLE.
  - `ready`=1; `busy`=0; `done`=0.
  - `sum`, `cout`, `overflow`, `acc`, the operand registers, `carry_q` and `idx` all go to 0.
  - An aborted operation produces no `done`.

## Timing

- Let E0 be the edge that samples `start`=1 in IDLE.
  - Edges E1..E_NIB each perform one nibble addition.
  - After E_NIB: `done`=1, and `sum`/`cout`/`overflow` are valid.
  - After E_NIB+1: state is IDLE and `ready`=1.
- Latency from E0 to `done` visible is NIB clocks; WIDTH=16 gives 4.
- Throughput is one operation per NIB+2 clocks with back-to-back starts.
- `ready` and `busy` are complementary and purely state-decoded.
- All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- Reset values: ready=1, busy=0, done=0, sum=0, cout=0, overflow=0.

## Test plan

Directed scenarios, all with WIDTH=16:
- Reset check: assert rst_n=0 and hold `start` high. Required: ready=1, busy=0, done=0, sum=0x0000, cout=0, overflow=0. Release reset with no clock edge in between; outputs must be unchanged.
- Basic add: a=0x1234, b=0x4321, cin=0, with one start pulse. Required: done=1 exactly 4 clocks after the accepting edge, sum=0x5555, cout=0, overflow=0, and done low on the next cycle.
- Full ripple: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1, overflow=0, which proves the carry propagates across all 4 nibble steps. Then a=0xFFFF, b=0xFFFF, cin=1. Required: sum=0xFFFF, cout=1.
- Signed overflow: a=0x7FFF, b=0x0000, cin=1. Required: sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000, cin=0. Required: sum=0x0000, cout=1, overflow=1.
- Handshake: start a=0x0003, b=0x0004. Then pulse start with a=0xAAAA, b=0x5555 during ADD and again during DONE. Required: both pulses ignored, result sum=0x0007, and the next start in IDLE is accepted normally.
- Mid-op reset: start a=0x1111, b=0x2222, then drop rst_n after E2. Required: all outputs 0 immediately, no done pulse, ready=1. A subsequent a=0x0F0F, b=0x0101 yields sum=0x1010, cout=0.
